// File: rtl/rr_arbiter8_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
// Pure declarations; no logic, no latency, no flow control.
// Imported by the arbiter top and its rotating priority encoder.
package rr_arbiter8_pkg;

    localparam int N            = 8;
    localparam int IDX_W        = 3;
    localparam int DEF_MAX_HOLD = 16;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    function automatic logic [N-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/rr_pri_encode8.sv
// Rotating priority encoder: first set req bit at or after ptr, wrapping past N-1.
// Latency: combinational, zero cycles.
// Backpressure: none; any=0 when no request is pending.
module rr_pri_encode8
    import rr_arbiter8_pkg::*;
(
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Offsets are added in IDX_W bits so the candidate index wraps mod N for free.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + IDX_W'(k);
            if (!any && req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with registered one-hot/binary grant and hold timeout.
// Latency: req -> gnt one cycle; a grant lasts at most MAX_HOLD cycles, then one idle bubble.
// Backpressure: a requester holds the resource while req stays high; timeout pulses on forced release.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             timeout
);

    localparam int HOLD_W = $clog2(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [IDX_W-1:0] win_idx;
    logic             win_any;

    rr_pri_encode8 u_pri (
        .req (req),
        .ptr (ptr),
        .idx (win_idx),
        .any (win_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    timeout <= 1'b0;
                    if (win_any) begin
                        gnt       <= idx_to_onehot(win_idx);
                        gnt_idx   <= win_idx;
                        gnt_valid <= 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (req[gnt_idx] && hold_cnt != HOLD_LAST) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end else begin
                        // Still requesting here means the hold limit forced the release.
                        timeout   <= req[gnt_idx];
                        gnt       <= '0;
                        gnt_valid <= 1'b0;
                        ptr       <= gnt_idx + 1'b1;
                        hold_cnt  <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: behavioural model feeds a queue of expected outputs per driven cycle,
// popped and compared one cycle later, plus directed checks on the key scenarios.
module tb_rr_arbiter8;

    localparam int MAXH = 16;

    typedef struct packed {
        logic [7:0] gnt;
        logic [2:0] idx;
        logic       valid;
        logic       to;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb[$];

    // reference model state
    bit m_busy;
    int m_ptr, m_hold, m_idx;
    bit m_to;

    rr_arbiter8 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_busy = 0; m_ptr = 0; m_hold = 0; m_idx = 0; m_to = 0;
        sb.delete();
    endtask

    task automatic model_step(input logic [7:0] r);
        bit found;
        int w;
        exp_t e;
        found = 0;
        if (!m_busy) begin
            m_to = 0;
            for (int k = 0; k < 8; k++) begin
                w = (m_ptr + k) % 8;
                if (!found && r[w]) begin
                    found  = 1;
                    m_idx  = w;
                end
            end
            if (found) begin
                m_busy = 1;
                m_hold = 0;
            end
        end else if (r[m_idx] && m_hold < MAXH - 1) begin
            m_hold++;
        end else begin
            m_to   = r[m_idx];
            m_busy = 0;
            m_ptr  = (m_idx + 1) % 8;
            m_hold = 0;
        end
        e.gnt   = m_busy ? (8'h01 << m_idx) : 8'h00;
        e.idx   = 3'(m_idx);
        e.valid = m_busy;
        e.to    = m_to;
        sb.push_back(e);
    endtask

    // Drive req just after an edge, let one edge pass, compare against the queued expectation.
    task automatic step(input logic [7:0] r);
        exp_t e;
        req = r;
        model_step(r);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check("gnt",     32'(gnt),       32'(e.gnt));
            check("gnt_idx", 32'(gnt_idx),   32'(e.idx));
            check("valid",   32'(gnt_valid), 32'(e.valid));
            check("timeout", 32'(timeout),   32'(e.to));
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_gnt"},   32'(gnt),       32'd0);
        check({tag, "_valid"}, 32'(gnt_valid), 32'd0);
        check({tag, "_to"},    32'(timeout),   32'd0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        req = 8'h00;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin : main
        logic [7:0] r;
        int  to_cnt;
        logic prev_valid;
        logic [2:0] seq [$];

        // 1: reset and idle
        #1;
        check_zero("t1_rst");
        check("t1_rst_idx", 32'(gnt_idx), 32'd0);
        apply_reset();
        for (int i = 0; i < 5; i++) step(8'h00);
        check_zero("t1_idle");

        // 2: lowest after ptr wins; ptr advances past the released winner
        step(8'hA0);
        check("t2_gnt", 32'(gnt), 32'h20);
        check("t2_idx", 32'(gnt_idx), 32'd5);
        step(8'h80);
        check("t2_rel", 32'(gnt), 32'h00);
        step(8'h80);
        check("t2_next_idx", 32'(gnt_idx), 32'd7);
        step(8'h00);
        step(8'h00);

        // 3: all requesting -> each grant times out after MAX_HOLD cycles
        apply_reset();
        to_cnt = 0;
        prev_valid = 1'b0;
        for (int i = 0; i < 9 * (MAXH + 1); i++) begin
            step(8'hFF);
            if (gnt_valid && !prev_valid) seq.push_back(gnt_idx);
            prev_valid = gnt_valid;
            if (timeout) to_cnt++;
        end
        check("t3_timeouts", 32'(to_cnt), 32'd9);
        check("t3_ngrants", 32'(seq.size()), 32'd9);
        for (int i = 0; i < 9 && i < seq.size(); i++)
            check("t3_seq", 32'(seq[i]), 32'(i % 8));
        step(8'h00);

        // 4: ptr at 7 wraps to requester 0 before 1
        step(8'h40);
        step(8'h40);
        step(8'h00);
        check("t4_rel", 32'(gnt), 32'h00);
        step(8'h03);
        check("t4_wrap_idx", 32'(gnt_idx), 32'd0);
        step(8'h00);
        step(8'h00);

        // 5: async reset mid-grant drops grant before the next edge
        apply_reset();
        step(8'h08);
        for (int i = 0; i < 5; i++) step(8'h08);
        check("t5_pre_idx", 32'(gnt_idx), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check_zero("t5_async");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_zero("t5_held");
        step(8'h08);
        check("t5_regrant_idx", 32'(gnt_idx), 32'd3);
        step(8'h00);
        step(8'h00);

        // 6: release and new requests on the same edge
        apply_reset();
        step(8'h04);
        check("t6_idx2", 32'(gnt_idx), 32'd2);
        step(8'h04);
        step(8'h03);
        check("t6_bubble", 32'(gnt), 32'h00);
        step(8'h03);
        check("t6_idx0", 32'(gnt_idx), 32'd0);

        // random traffic with slowly changing request vectors
        r = 8'h00;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) r = r ^ (8'h01 << $urandom_range(0, 7));
            step(r);
            check("onehot_valid", 32'(gnt_valid), 32'(|gnt));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
